// File: rtl/dla_noc_packetizer_pkg.sv
// Shared flit definitions for the DLA NoC packetizer: flit labels, field
// widths, packetizer FSM states and the head-data field packing helper.
package dla_noc_packetizer_pkg;

  localparam int FLIT_DATA_SIZE   = 32;
  localparam int FLIT_LABEL_SIZE  = 2;
  localparam int FLIT_TOTAL_SIZE  = FLIT_LABEL_SIZE + FLIT_DATA_SIZE;
  localparam int DEST_ADDR_SIZE_X = 4;
  localparam int DEST_ADDR_SIZE_Y = 4;
  localparam int DEST_ADDR_SIZE_L = 2;
  localparam int HEAD_PL_SIZE     = DEST_ADDR_SIZE_X + DEST_ADDR_SIZE_Y + 2;

  typedef enum logic [FLIT_LABEL_SIZE-1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    ZTAIL   = 2'd2
  } pktz_state_t;

  // Head data: l in the LSBs, then y, then x, then the optional head payload.
  function automatic logic [FLIT_DATA_SIZE-1:0] head_data(
    input logic [DEST_ADDR_SIZE_X-1:0] x,
    input logic [DEST_ADDR_SIZE_Y-1:0] y,
    input logic [DEST_ADDR_SIZE_L-1:0] l,
    input logic [HEAD_PL_SIZE-1:0]     pl
  );
    logic [FLIT_DATA_SIZE-1:0] d;
    d = '0;
    d[0+:DEST_ADDR_SIZE_L] = l;
    d[DEST_ADDR_SIZE_L+:DEST_ADDR_SIZE_Y] = y;
    d[DEST_ADDR_SIZE_L+DEST_ADDR_SIZE_Y+:DEST_ADDR_SIZE_X] = x;
    d[DEST_ADDR_SIZE_L+DEST_ADDR_SIZE_Y+DEST_ADDR_SIZE_X+:HEAD_PL_SIZE] = pl;
    return d;
  endfunction

endpackage

// File: rtl/dla_noc_packetizer_stat.sv
// Saturating event counters for the packetizer (built only with DLA_PKT_STAT_EN).
module dla_pkt_stat (
  input  logic        clk_dla,
  input  logic        rst_dla,
  input  logic        i_inc_pkt,
  input  logic        i_inc_grnt,
  input  logic        i_inc_stall,
  output logic [31:0] o_pkt,
  output logic [31:0] o_grnt,
  output logic [31:0] o_stall
);

  logic [31:0] r_pkt, r_grnt, r_stall;

  // Count each event, holding at all-ones instead of wrapping.
  always_ff @(posedge clk_dla or posedge rst_dla) begin
    if (rst_dla) begin
      r_pkt   <= '0;
      r_grnt  <= '0;
      r_stall <= '0;
    end else begin
      if (i_inc_pkt   && (r_pkt   != '1)) r_pkt   <= r_pkt   + 32'd1;
      if (i_inc_grnt  && (r_grnt  != '1)) r_grnt  <= r_grnt  + 32'd1;
      if (i_inc_stall && (r_stall != '1)) r_stall <= r_stall + 32'd1;
    end
  end

  assign o_pkt   = r_pkt;
  assign o_grnt  = r_grnt;
  assign o_stall = r_stall;

endmodule

// File: rtl/dla_noc_packetizer.sv
// DLA-side flit builder: turns packet and grant-return requests into
// HEAD/BODY/TAIL/HEADTAIL flits for the DLA->router async flit FIFO.
// Optional statistics counters are enabled with `define DLA_PKT_STAT_EN.
module dla_noc_packetizer
  import dla_noc_packetizer_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic                        clk_dla,
  input  logic                        rst_dla,
  input  logic                        req_vld,
  output logic                        req_rdy,
  input  logic [DEST_ADDR_SIZE_X-1:0] req_x,
  input  logic [DEST_ADDR_SIZE_Y-1:0] req_y,
  input  logic [DEST_ADDR_SIZE_L-1:0] req_l,
  input  logic [LEN_W-1:0]            req_len,
  input  logic                        dat_vld,
  output logic                        dat_rdy,
  input  logic [FLIT_DATA_SIZE-1:0]   dat,
  input  logic                        grnt_vld,
  output logic                        grnt_rdy,
  input  logic [DEST_ADDR_SIZE_X-1:0] grnt_dst_x,
  input  logic [DEST_ADDR_SIZE_Y-1:0] grnt_dst_y,
  input  logic [DEST_ADDR_SIZE_L-1:0] grnt_dst_l,
  input  logic [DEST_ADDR_SIZE_X-1:0] grnt_x,
  input  logic [DEST_ADDR_SIZE_Y-1:0] grnt_y,
  input  logic [1:0]                  grnt_dla,
  input  logic                        wbuf_full,
  input  logic                        wbuf_afull,
  output logic                        wbuf_wen,
  output logic [FLIT_TOTAL_SIZE-1:0]  wbuf_wdata,
  output logic                        busy
`ifdef DLA_PKT_STAT_EN
  ,
  output logic [31:0]                 stat_pkt,
  output logic [31:0]                 stat_grnt,
  output logic [31:0]                 stat_stall
`endif
);

  pktz_state_t               r_state, w_nxt;
  logic [LEN_W-1:0]          r_cnt, w_cnt_nxt;
  logic                      r_last_grnt, w_last_nxt;
  logic                      r_wen;
  logic [FLIT_TOTAL_SIZE-1:0] r_wdata;
  logic                      w_can, w_issue;
  logic                      w_req_rdy, w_dat_rdy, w_grnt_rdy;
  flit_label_t               w_lbl;
  logic [FLIT_DATA_SIZE-1:0] w_data;

  // Two free FIFO entries are required before any flit is issued.
  assign w_can = !wbuf_full && !wbuf_afull;

  // Next state, handshakes and the flit to issue this cycle.
  always_comb begin
    w_nxt      = r_state;
    w_cnt_nxt  = r_cnt;
    w_last_nxt = r_last_grnt;
    w_req_rdy  = 1'b0;
    w_dat_rdy  = 1'b0;
    w_grnt_rdy = 1'b0;
    w_issue    = 1'b0;
    w_lbl      = HEAD;
    w_data     = '0;
    case (r_state)
      IDLE: begin
        if (w_can) begin
          // On contention, the grant wins unless it was served last.
          if (grnt_vld && (!req_vld || !r_last_grnt)) begin
            w_grnt_rdy = 1'b1;
            w_issue    = 1'b1;
            w_lbl      = HEADTAIL;
            w_data     = head_data(grnt_dst_x, grnt_dst_y, grnt_dst_l,
                                   {grnt_x, grnt_y, grnt_dla});
            w_last_nxt = 1'b1;
          end else if (req_vld) begin
            w_req_rdy  = 1'b1;
            w_issue    = 1'b1;
            w_lbl      = HEAD;
            w_data     = head_data(req_x, req_y, req_l, '0);
            w_last_nxt = 1'b0;
            if (req_len != '0) begin
              w_cnt_nxt = req_len;
              w_nxt     = PAYLOAD;
            end else begin
              w_nxt     = ZTAIL;
            end
          end
        end
      end
      PAYLOAD: begin
        w_dat_rdy = w_can;
        if (dat_vld && w_can) begin
          w_issue   = 1'b1;
          w_data    = dat;
          w_cnt_nxt = r_cnt - 1'b1;
          if (r_cnt == LEN_W'(1)) begin
            w_lbl = TAIL;
            w_nxt = IDLE;
          end else begin
            w_lbl = BODY;
          end
        end
      end
      ZTAIL: begin
        if (w_can) begin
          w_issue = 1'b1;
          w_lbl   = TAIL;
          w_nxt   = IDLE;
        end
      end
      default: w_nxt = IDLE;
    endcase
  end

  // FSM state, payload counter and arbitration history.
  always_ff @(posedge clk_dla or posedge rst_dla) begin
    if (rst_dla) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_last_grnt <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_cnt       <= w_cnt_nxt;
      r_last_grnt <= w_last_nxt;
    end
  end

  // Registered FIFO write port; data is zeroed on idle cycles.
  always_ff @(posedge clk_dla or posedge rst_dla) begin
    if (rst_dla) begin
      r_wen   <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_wen   <= w_issue;
      r_wdata <= w_issue ? {w_lbl, w_data} : '0;
    end
  end

  assign wbuf_wen   = r_wen;
  assign wbuf_wdata = r_wdata;
  assign busy       = (r_state != IDLE);
  assign req_rdy    = w_req_rdy  & ~rst_dla;
  assign dat_rdy    = w_dat_rdy  & ~rst_dla;
  assign grnt_rdy   = w_grnt_rdy & ~rst_dla;

`ifdef DLA_PKT_STAT_EN
  logic w_pend;
  // Work is pending whenever a request waits or a packet is open.
  assign w_pend = (r_state != IDLE) || req_vld || grnt_vld;

  dla_pkt_stat u_stat (
    .clk_dla     (clk_dla),
    .rst_dla     (rst_dla),
    .i_inc_pkt   (w_req_rdy  & ~rst_dla),
    .i_inc_grnt  (w_grnt_rdy & ~rst_dla),
    .i_inc_stall (w_pend && !w_can),
    .o_pkt       (stat_pkt),
    .o_grnt      (stat_grnt),
    .o_stall     (stat_stall)
  );
`endif

endmodule

// File: tb/tb_dla_noc_packetizer.sv
// Bench for dla_noc_packetizer: directed scenarios plus randomized traffic,
// checked against an expected-flit queue built from the flit format rules.
module tb_dla_noc_packetizer;
  import dla_noc_packetizer_pkg::*;

  logic        clk_dla = 1'b0;
  logic        rst_dla = 1'b1;
  logic        req_vld = 0, dat_vld = 0, grnt_vld = 0, wbuf_full;
  logic        req_rdy, dat_rdy, grnt_rdy, wbuf_afull, wbuf_wen, busy;
  logic [3:0]  req_x = 0, req_y = 0, grnt_dst_x = 0, grnt_dst_y = 0, grnt_x = 0, grnt_y = 0;
  logic [1:0]  req_l = 0, grnt_dst_l = 0, grnt_dla = 0;
  logic [7:0]  req_len = 0;
  logic [31:0] dat = 0;
  logic [33:0] wbuf_wdata;
  logic        rnd_en = 0, rnd_afull = 0, rnd_full = 0, dir_afull = 0;
`ifdef DLA_PKT_STAT_EN
  logic [31:0] stat_pkt, stat_grnt, stat_stall;
`endif

  assign wbuf_afull = rnd_en ? rnd_afull : dir_afull;
  assign wbuf_full  = rnd_en ? rnd_full  : 1'b0;

  always #5 clk_dla = ~clk_dla;

  dla_noc_packetizer #(.LEN_W(8)) dut (
    .clk_dla(clk_dla), .rst_dla(rst_dla),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_x(req_x), .req_y(req_y), .req_l(req_l),
    .req_len(req_len), .dat_vld(dat_vld), .dat_rdy(dat_rdy), .dat(dat),
    .grnt_vld(grnt_vld), .grnt_rdy(grnt_rdy), .grnt_dst_x(grnt_dst_x),
    .grnt_dst_y(grnt_dst_y), .grnt_dst_l(grnt_dst_l), .grnt_x(grnt_x), .grnt_y(grnt_y),
    .grnt_dla(grnt_dla), .wbuf_full(wbuf_full), .wbuf_afull(wbuf_afull),
    .wbuf_wen(wbuf_wen), .wbuf_wdata(wbuf_wdata), .busy(busy)
`ifdef DLA_PKT_STAT_EN
    , .stat_pkt(stat_pkt), .stat_grnt(stat_grnt), .stat_stall(stat_stall)
`endif
  );

  int n_chk = 0, n_pass = 0;
  logic [33:0] exp_q[$];
  bit          m_last_g = 0;
  int          m_pkt = 0, m_grnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Expected flit words from the bridge-visible layout.
  function automatic logic [33:0] f_head(input int x, y, l);
    return {HEAD, 32'(x * 64 + y * 4 + l)};
  endfunction
  function automatic logic [33:0] f_ht(input int x, y, l, gx, gy, gd);
    return {HEADTAIL, 32'(x * 64 + y * 4 + l + (gd + gy * 4 + gx * 64) * 1024)};
  endfunction

  // Every written flit must be the next expected one; idle cycles carry zero.
  always @(negedge clk_dla) begin
    if (wbuf_wen) begin
      if (exp_q.size() == 0) chk("flit_extra", 64'(wbuf_wen), 64'd0);
      else chk("flit", 64'(wbuf_wdata), 64'(exp_q.pop_front()));
    end else chk("idle_wdata", 64'(wbuf_wdata), 64'd0);
  end

  always @(negedge clk_dla) begin
    rnd_afull = ($urandom_range(0, 3) == 0);
    rnd_full  = ($urandom_range(0, 15) == 0);
  end

  // Waits (bounded) for the selected ready while inputs are held; called at a negedge.
  task automatic hs(input int sel, output bit ok);
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      #1;
      if ((sel == 0 && req_rdy) || (sel == 1 && dat_rdy) || (sel == 2 && grnt_rdy)) begin
        ok = 1;
        break;
      end
      @(negedge clk_dla);
    end
    chk("hs_timeout", 64'(ok), 64'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit last, input int gap);
    bit ok;
    repeat (gap) @(negedge clk_dla);
    dat_vld = 1; dat = w;
    hs(1, ok);
    exp_q.push_back({last ? TAIL : BODY, w});
    @(negedge clk_dla);
    dat_vld = 0;
  endtask

  task automatic pkt(input int x, y, l, n, input int maxgap);
    bit ok;
    req_x = 4'(x); req_y = 4'(y); req_l = 2'(l); req_len = 8'(n); req_vld = 1;
    hs(0, ok);
    exp_q.push_back(f_head(x, y, l));
    m_pkt++; m_last_g = 0;
    if (n == 0) exp_q.push_back({TAIL, 32'd0});
    @(negedge clk_dla);
    req_vld = 0;
    for (int i = 0; i < n; i++)
      send_word($urandom, i == n - 1, $urandom_range(0, maxgap));
  endtask

  task automatic grant(input int dx, dy, dl, gx, gy, gd);
    bit ok;
    grnt_dst_x = 4'(dx); grnt_dst_y = 4'(dy); grnt_dst_l = 2'(dl);
    grnt_x = 4'(gx); grnt_y = 4'(gy); grnt_dla = 2'(gd); grnt_vld = 1;
    hs(2, ok);
    exp_q.push_back(f_ht(dx, dy, dl, gx, gy, gd));
    m_grnt++; m_last_g = 1;
    @(negedge clk_dla);
    grnt_vld = 0;
  endtask

  // Request and grant raised together: the one not served last goes first.
  task automatic both(input int x, y, l);
    bit ok, gfirst;
    int gx, gy, gd;
    logic [31:0] w;
    gfirst = !m_last_g;
    gx = $urandom_range(0, 15); gy = $urandom_range(0, 15); gd = $urandom_range(0, 3);
    w = $urandom;
    req_x = 4'(x); req_y = 4'(y); req_l = 2'(l); req_len = 8'd1; req_vld = 1;
    grnt_dst_x = 4'(y); grnt_dst_y = 4'(x); grnt_dst_l = 2'(l);
    grnt_x = 4'(gx); grnt_y = 4'(gy); grnt_dla = 2'(gd); grnt_vld = 1;
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      #1;
      if (req_rdy || grnt_rdy) begin ok = 1; break; end
      @(negedge clk_dla);
    end
    chk("arb_timeout", 64'(ok), 64'd1);
    chk("arb_order", 64'({grnt_rdy, req_rdy}), gfirst ? 64'd2 : 64'd1);
    if (gfirst) begin
      exp_q.push_back(f_ht(y, x, l, gx, gy, gd)); m_grnt++;
      @(negedge clk_dla);
      grnt_vld = 0;
      hs(0, ok);
      exp_q.push_back(f_head(x, y, l)); m_pkt++;
      @(negedge clk_dla);
      req_vld = 0;
      send_word(w, 1, 0);
      m_last_g = 0;
    end else begin
      exp_q.push_back(f_head(x, y, l)); m_pkt++;
      @(negedge clk_dla);
      req_vld = 0;
      #1 chk("no_grnt_in_pkt", 64'(grnt_rdy), 64'd0);
      send_word(w, 1, 1);
      hs(2, ok);
      exp_q.push_back(f_ht(y, x, l, gx, gy, gd)); m_grnt++;
      @(negedge clk_dla);
      grnt_vld = 0;
      m_last_g = 1;
    end
  endtask

  initial begin
    bit ok;
`ifdef DLA_PKT_STAT_EN
    logic [31:0] s0;
`endif
    // Reset state, with requests pending that must not be acknowledged.
    req_vld = 1; grnt_vld = 1;
    @(negedge clk_dla);
    #1;
    chk("rst_wen", 64'(wbuf_wen), 0);
    chk("rst_wdata", 64'(wbuf_wdata), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_req_rdy", 64'(req_rdy), 0);
    chk("rst_grnt_rdy", 64'(grnt_rdy), 0);
    req_vld = 0; grnt_vld = 0;
    @(negedge clk_dla);
    rst_dla = 0;
    @(negedge clk_dla);

    // 1: N=3 packet, busy until TAIL handed over.
    req_x = 3; req_y = 2; req_l = 1; req_len = 3; req_vld = 1;
    hs(0, ok);
    exp_q.push_back(f_head(3, 2, 1)); m_pkt++; m_last_g = 0;
    @(negedge clk_dla);
    req_vld = 0;
    chk("t1_busy", 64'(busy), 1);
    send_word(32'hA, 0, 0);
    send_word(32'hB, 0, 1);
    send_word(32'hC, 1, 0);
    chk("t1_busy_end", 64'(busy), 0);

    // 2: grant return.
    grant(1, 0, 0, 5, 6, 2);

    // 3: contention twice; history now says the grant went last.
    m_last_g = 1;
    both(7, 1, 2);
    both(2, 9, 3);

    // 4: almost-full for 5 cycles mid-payload.
    req_x = 4; req_y = 4; req_l = 0; req_len = 3; req_vld = 1;
    hs(0, ok);
    exp_q.push_back(f_head(4, 4, 0)); m_pkt++; m_last_g = 0;
    @(negedge clk_dla);
    req_vld = 0;
    send_word(32'h1111, 0, 0);
    dat_vld = 1; dat = 32'h2222; dir_afull = 1;
`ifdef DLA_PKT_STAT_EN
    #1 s0 = stat_stall;
`endif
    for (int i = 0; i < 5; i++) begin
      #2 chk("t4_dat_rdy", 64'(dat_rdy), 0);
      @(negedge clk_dla);
    end
    dir_afull = 0;
`ifdef DLA_PKT_STAT_EN
    #1 chk("t4_stall", 64'(stat_stall - s0), 5);
    @(negedge clk_dla);
`endif
    send_word(32'h2222, 0, 0);
    send_word(32'h3333, 1, 0);

    // 5: zero-length packet; data is never consumed.
    req_x = 9; req_y = 8; req_l = 3; req_len = 0; req_vld = 1;
    hs(0, ok);
    exp_q.push_back(f_head(9, 8, 3)); exp_q.push_back({TAIL, 32'd0}); m_pkt++; m_last_g = 0;
    @(negedge clk_dla);
    req_vld = 0; dat_vld = 1; dat = 32'hDEAD;
    #1 chk("t5_busy", 64'(busy), 1);
    chk("t5_dat_rdy", 64'(dat_rdy), 0);
    @(negedge clk_dla);
    #1 chk("t5_dat_rdy2", 64'(dat_rdy), 0);
    chk("t5_idle", 64'(busy), 0);
    dat_vld = 0;
    @(negedge clk_dla);

    // 6: reset after the first BODY of an N=4 packet.
    req_x = 1; req_y = 1; req_l = 1; req_len = 4; req_vld = 1;
    hs(0, ok);
    exp_q.push_back(f_head(1, 1, 1)); m_pkt++;
    @(negedge clk_dla);
    req_vld = 0;
    send_word(32'h5555, 0, 0);
    #2 rst_dla = 1;
    #1 chk("t6_wen", 64'(wbuf_wen), 0);
    chk("t6_busy", 64'(busy), 0);
    @(negedge clk_dla);
    rst_dla = 0;
    m_pkt = 0; m_grnt = 0; m_last_g = 0;
    @(negedge clk_dla);
    chk("t6_q_empty", 64'(exp_q.size()), 0);
    pkt(6, 5, 2, 0, 0);

    // Randomized traffic under random back-pressure.
    rnd_en = 1;
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 3))
        0: grant($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3),
                 $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3));
        1: both($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3));
        default: pkt($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3),
                     $urandom_range(0, 5), 2);
      endcase
    end
    rnd_en = 0;
    repeat (5) @(negedge clk_dla);
    chk("drained", 64'(exp_q.size()), 0);
    chk("final_busy", 64'(busy), 0);
`ifdef DLA_PKT_STAT_EN
    chk("stat_pkt", 64'(stat_pkt), 64'(m_pkt));
    chk("stat_grnt", 64'(stat_grnt), 64'(m_grnt));
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
